// File: rtl/mac_1g_gmii_tx_if.sv
// Byte stream from mac_1g_tx into the GMII transmit buffer.
// Master drives data/valid/last, slave returns ready.
interface mac_1g_gmii_tx_if;
   logic [7:0] Mac_data;
   logic       Mac_valid;
   logic       Mac_last;
   logic       Mac_ready;

   modport master (
      output Mac_data,
      output Mac_valid,
      output Mac_last,
      input  Mac_ready
   );

   modport slave (
      input  Mac_data,
      input  Mac_valid,
      input  Mac_last,
      output Mac_ready
   );
endinterface

// File: rtl/mac_1g_gmii_tx.sv
// GMII transmit stage: byte FIFO, start gating, IPG enforcement
// and underrun abort with TX_ER.
module mac_1g_gmii_tx #(
   parameter int FIFO_DEPTH      = 2048,
   parameter int START_THRESHOLD = 1536,
   parameter int IPG_BYTES       = 12
) (
   input  logic            Clk,
   input  logic            Rst_n,
   mac_1g_gmii_tx_if.slave mac,
   output logic [7:0]      Gmii_txd,
   output logic            Gmii_tx_en,
   output logic            Gmii_tx_er,
   output logic [31:0]     Frame_count,
   output logic [15:0]     Underrun_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TX, S_UNDERRUN, S_DISCARD, S_IPG
   } state_t;

   state_t state, state_nxt;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level, level_nxt, frames;
   logic [7:0]    ipg_cnt, ipg_init;
   logic [7:0]    rd_data, txd_nxt;
   logic          rd_last, wr_en, rd_en, empty, start, take;
   logic          ready_q, en_nxt, er_nxt;
   logic          frame_inc, urun_inc, ipg_load;

   assign mac.Mac_ready = ready_q;
   assign wr_en = mac.Mac_valid && ready_q;
   assign empty = (level == '0);
   assign {rd_last, rd_data} = mem[rd_ptr];
   assign start = (frames != '0) ||
                  (32'(level) >= 32'(START_THRESHOLD));
   assign level_nxt = level + (AW+1)'(wr_en) - (AW+1)'(rd_en);

   always_ff @(posedge Clk) begin
      if (wr_en) mem[wr_ptr] <= {mac.Mac_last, mac.Mac_data};
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      rd_en     = 1'b0;
      en_nxt    = 1'b0;
      er_nxt    = 1'b0;
      txd_nxt   = 8'h00;
      frame_inc = 1'b0;
      urun_inc  = 1'b0;
      ipg_load  = 1'b0;
      ipg_init  = 8'd0;
      unique case (state)
         S_IDLE: take = start;
         S_TX: begin
            if (empty) begin
               en_nxt    = 1'b1;
               er_nxt    = 1'b1;
               urun_inc  = 1'b1;
               state_nxt = S_UNDERRUN;
            end else begin
               take = 1'b1;
            end
         end
         S_UNDERRUN: state_nxt = S_DISCARD;
         S_DISCARD: begin
            if (!empty) begin
               rd_en = 1'b1;
               if (rd_last) begin
                  state_nxt = S_IPG;
                  ipg_load  = 1'b1;
                  ipg_init  = 8'd1;
               end
            end
         end
         S_IPG: begin
            // last idle cycle doubles as the IDLE start check
            if (ipg_cnt == 8'(IPG_BYTES)) begin
               state_nxt = S_IDLE;
               take      = start;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (take) begin
         rd_en   = 1'b1;
         en_nxt  = 1'b1;
         txd_nxt = rd_data;
         if (rd_last) begin
            frame_inc = 1'b1;
            state_nxt = S_IPG;
            ipg_load  = 1'b1;
         end else begin
            state_nxt = S_TX;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= S_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         frames         <= '0;
         ready_q        <= 1'b0;
         ipg_cnt        <= 8'd0;
         Gmii_txd       <= 8'h00;
         Gmii_tx_en     <= 1'b0;
         Gmii_tx_er     <= 1'b0;
         Frame_count    <= 32'd0;
         Underrun_count <= 16'd0;
      end else begin
         state   <= state_nxt;
         level   <= level_nxt;
         ready_q <= (level_nxt < FULL_LVL);
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en && mac.Mac_last, rd_en && rd_last})
            2'b10:   frames <= frames + (AW+1)'(1);
            2'b01:   frames <= frames - (AW+1)'(1);
            default: frames <= frames;
         endcase
         if (ipg_load) ipg_cnt <= ipg_init;
         else if (state == S_IPG) ipg_cnt <= ipg_cnt + 8'd1;
         Gmii_txd   <= txd_nxt;
         Gmii_tx_en <= en_nxt;
         Gmii_tx_er <= er_nxt;
         if (frame_inc) Frame_count <= Frame_count + 32'd1;
         if (urun_inc && Underrun_count != 16'hFFFF)
            Underrun_count <= Underrun_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_mac_1g_gmii_tx.sv
// Scoreboard bench for mac_1g_gmii_tx: expected GMII bytes are queued
// at stimulus time and popped by a negedge monitor.
module tb_mac_1g_gmii_tx;
   localparam int DEPTH = 128;
   localparam int THR   = 40;
   localparam int IPG   = 12;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #4 Clk = ~Clk;

   mac_1g_gmii_tx_if m_if ();
   mac_1g_gmii_tx_if f_if ();

   logic [7:0]  txd, f_txd;
   logic        en, er, f_en, f_er;
   logic [31:0] fc, f_fc;
   logic [15:0] uc, f_uc;

   mac_1g_gmii_tx #(
      .FIFO_DEPTH(DEPTH), .START_THRESHOLD(THR), .IPG_BYTES(IPG)
   ) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .mac(m_if.slave),
      .Gmii_txd(txd), .Gmii_tx_en(en), .Gmii_tx_er(er),
      .Frame_count(fc), .Underrun_count(uc)
   );

   // threshold above depth: only a complete frame could start this one
   mac_1g_gmii_tx #(
      .FIFO_DEPTH(64), .START_THRESHOLD(100), .IPG_BYTES(IPG)
   ) u_fill (
      .Clk(Clk), .Rst_n(Rst_n), .mac(f_if.slave),
      .Gmii_txd(f_txd), .Gmii_tx_en(f_en), .Gmii_tx_er(f_er),
      .Frame_count(f_fc), .Underrun_count(f_uc)
   );

   typedef struct {
      logic       err;
      logic [7:0] d;
      logic       first;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   idle = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] fb(input logic [7:0] seed, input int i);
      if (i < 7) return 8'h55;
      if (i == 7) return 8'hD5;
      return seed ^ 8'(i);
   endfunction

   always @(negedge Clk) begin
      if (!mon_en) begin
         idle = 0;
      end else if (!en) begin
         chk("idle_outputs", {23'd0, er, txd}, 32'd0);
         idle++;
      end else begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", exp_q.size(), 32'd1);
         end else begin
            e = exp_q.pop_front();
            if (e.err) chk("err_cycle", {23'd0, er, txd}, 32'h100);
            else chk("tx_byte", {23'd0, er, txd}, {24'd0, e.d});
            if (e.first && e.gap >= 0) chk("ipg_gap", idle, e.gap);
            if (!e.first) chk("contiguous", idle, 32'd0);
         end
         idle = 0;
      end
   end

   task automatic push_frame(input int len, input logic [7:0] seed,
                             input int gap, input bit err);
      for (int i = 0; i < len; i++)
         exp_q.push_back('{1'b0, fb(seed, i), i == 0, (i == 0) ? gap : -1});
      if (err) exp_q.push_back('{1'b1, 8'h00, 1'b0, -1});
   endtask

   task automatic wait_accept(output bit ok);
      bit r;
      ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         r = m_if.Mac_ready;
         @(posedge Clk);
         #1;
         if (!Rst_n) return;
         if (r) begin
            ok = 1'b1;
            return;
         end
      end
      chk("ready_timeout", 32'd4000, 32'd0);
   endtask

   task automatic send(input int len, input logic [7:0] seed,
                       input int hold_at, input int hold_len);
      bit ok;
      for (int i = 0; i < len; i++) begin
         if (i == hold_at) begin
            m_if.Mac_valid = 1'b0;
            repeat (hold_len) @(posedge Clk);
            #1;
         end
         m_if.Mac_data  = fb(seed, i);
         m_if.Mac_last  = (i == len - 1);
         m_if.Mac_valid = 1'b1;
         wait_accept(ok);
         if (!ok) break;
      end
      m_if.Mac_valid = 1'b0;
      m_if.Mac_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge Clk);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
      repeat (IPG + 4) @(posedge Clk);
      #1;
   endtask

   initial begin
      int acc;
      bit r;
      m_if.Mac_valid = 1'b0;
      m_if.Mac_last  = 1'b0;
      m_if.Mac_data  = 8'h00;
      f_if.Mac_valid = 1'b0;
      f_if.Mac_last  = 1'b0;
      f_if.Mac_data  = 8'h00;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_ready", m_if.Mac_ready, 32'd0);
      chk("rst_tx", {23'd0, en, er, 7'd0}, 32'd0);
      chk("rst_txd", txd, 32'd0);
      chk("rst_frames", fc, 32'd0);
      chk("rst_underruns", uc, 32'd0);
      #2 Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      chk("ready_after_release", m_if.Mac_ready, 32'd1);
      mon_en = 1'b1;

      push_frame(72, 8'h10, -1, 1'b0);
      send(72, 8'h10, -1, 0);
      drain();
      chk("frame_count_single", fc, 32'd1);

      push_frame(64, 8'h20, -1, 1'b0);
      push_frame(64, 8'h30, IPG, 1'b0);
      push_frame(64, 8'h40, IPG, 1'b0);
      send(64, 8'h20, -1, 0);
      send(64, 8'h30, -1, 0);
      send(64, 8'h40, -1, 0);
      drain();
      chk("frame_count_b2b", fc, 32'd4);

      // stream stalls after 50 bytes: those 50 go out, then TX_ER
      push_frame(50, 8'h50, -1, 1'b1);
      send(100, 8'h50, 50, 200);
      push_frame(64, 8'h60, -1, 1'b0);
      send(64, 8'h60, -1, 0);
      drain();
      chk("underrun_count", uc, 32'd1);
      chk("frame_count_after_underrun", fc, 32'd5);

      acc = 0;
      f_if.Mac_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         r = f_if.Mac_ready;
         f_if.Mac_data = 8'(acc);
         @(posedge Clk);
         #1;
         if (r) acc++;
      end
      f_if.Mac_valid = 1'b0;
      chk("fill_accepted", acc, 32'd63);
      chk("fill_ready_low", f_if.Mac_ready, 32'd0);
      chk("fill_no_tx", {31'd0, f_en}, 32'd0);

      mon_en = 1'b0;
      exp_q.delete();
      fork
         send(100, 8'h70, -1, 0);
      join_none
      acc = 0;
      while (!en && acc < 500) begin
         @(posedge Clk);
         #1;
         acc++;
      end
      chk("midframe_tx_started", {31'd0, en}, 32'd1);
      repeat (30) @(posedge Clk);
      #3 Rst_n = 1'b0;
      #1;
      chk("async_drop_en", {31'd0, en}, 32'd0);
      chk("async_txd", txd, 32'd0);
      chk("async_frames", fc, 32'd0);
      chk("async_underruns", uc, 32'd0);
      chk("async_ready", m_if.Mac_ready, 32'd0);
      repeat (4) @(posedge Clk);
      #3 Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      mon_en = 1'b1;
      push_frame(64, 8'h80, -1, 1'b0);
      send(64, 8'h80, -1, 0);
      drain();
      chk("frame_count_after_reset", fc, 32'd1);
      chk("underrun_after_reset", uc, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mac_1g_gmii_tx.md
Name: mac_1g_gmii_tx

Overview:
- Downstream neighbour of mac_1g_tx. Consumes its framed byte stream (preamble, SFD, header, payload, pad, FCS) over an 8-bit valid/ready/last interface and drives a GMII transmit port.
- GMII cannot stall mid-frame, so frames are buffered in a byte FIFO. A frame starts only once it is fully buffered or enough bytes are queued.
- Enforces inter-packet gap and flags mid-frame underrun with TX_ER.

Parameters:
- FIFO_DEPTH, 2048, byte entries in the internal FIFO; power of 2, at least 64.
- START_THRESHOLD, 1536, FIFO level that starts a frame before its last byte arrives; must be less than FIFO_DEPTH.
- IPG_BYTES, 12, idle cycles (TX_EN=0) enforced after each frame; range 1..255.

Ports:
- Clk  in  1  clock, 125 MHz.
- Rst_n  in  1  asynchronous active-low reset.
- Mac_data  in  8  frame byte from mac_1g_tx.
- Mac_valid  in  1  Mac_data valid.
- Mac_last  in  1  final byte of frame (last FCS byte).
- Mac_ready  out  1  FIFO can accept a byte.
- Gmii_txd  out  8  GMII transmit data.
- Gmii_tx_en  out  1  GMII transmit enable.
- Gmii_tx_er  out  1  GMII transmit error.
- Frame_count  out  32  frames completed without error; wraps at 2^32.
- Underrun_count  out  16  frames aborted by underrun; saturates at 16'hFFFF.

Behaviour:
- Reset (Rst_n=0, async): FIFO emptied; state IDLE. Mac_ready, Gmii_tx_en, Gmii_tx_er, Gmii_txd, both counters and the IPG counter all 0. Mac_ready rises on the first clock edge after reset release.
- FIFO:
  - Entries are 9 bits: {last, data}.
  - Write occurs when Mac_valid && Mac_ready.
  - Mac_ready is registered and equals (level < FIFO_DEPTH-1) after the update, so a write in the cycle it deasserts cannot overflow.
  - A simultaneous read and write leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Complete-frame counter:
  - Increments on writes with last=1 and decrements on reads of a last=1 entry; both in one cycle leaves it unchanged.
  - Width is clog2(FIFO_DEPTH)+1.
- States:
  - IDLE: start when frames_buffered>0 or level>=START_THRESHOLD. The FIFO read happens in the start cycle; go to TX.
  - TX:
    - Read one byte per cycle. The output register presents the byte on Gmii_txd with Gmii_tx_en=1, Gmii_tx_er=0, exactly one cycle after its read (fixed read-to-pin latency of 1).
    - On reading last=1: stop reading, go to IPG, and increment Frame_count in the cycle the last byte is driven.
    - If the FIFO is empty while a byte is required: go to UNDERRUN.
  - UNDERRUN:
    - Drive Gmii_tx_en=1, Gmii_tx_er=1, Gmii_txd=8'h00 for exactly one cycle, then Gmii_tx_en=0.
    - Increment Underrun_count (saturating).
    - Go to DISCARD.
  - DISCARD:
    - Read and drop FIFO bytes whenever non-empty, with Gmii_tx_en=0 throughout.
    - On dropping last=1, go to IPG.
    - Mac_ready continues to follow the FIFO level.
  - IPG:
    - Gmii_tx_en=0, Gmii_tx_er=0, Gmii_txd=0 for IPG_BYTES cycles counted from the first idle cycle after the final driven byte (or after the error cycle).
    - Then go to IDLE; the start condition can be evaluated in that same cycle.
- Output rules:
  - Gmii_txd=0 whenever Gmii_tx_en=0.
  - Gmii_tx_er is only ever 1 together with Gmii_tx_en=1.
- No content checks: preamble, SFD and FCS pass through unmodified.
- Mid-frame Rst_n assertion: Gmii_tx_en drops asynchronously; the partial frame and buffered data are lost.
- Back-to-back frames already buffered are separated by exactly IPG_BYTES idle cycles.

Test Plan:
- 72-byte frame (7x55, D5, 60 data bytes, 4 FCS) written at full rate with Mac_ready held → Gmii_tx_en high for 72 consecutive cycles, bytes identical and in order, Gmii_tx_er=0, Frame_count=1.
- Three 64-byte frames pushed back-to-back → exactly 12 idle cycles between each pair of frames; Frame_count=3.
- 1600-byte frame with START_THRESHOLD=1536 and upstream valid dropping for 200 cycles at byte 1550 → transmission starts before last arrives; one cycle with TX_EN=1/TX_ER=1; remaining bytes dropped; Underrun_count=1; the next 64-byte frame is transmitted cleanly after 12 idle cycles.
- Fill the FIFO with GMII held in IPG using 2048 bytes of partial frames (no last) and START_THRESHOLD raised above FIFO_DEPTH through a test parameter → Mac_ready deasserts at level 2047; no byte is lost or duplicated.
- Rst_n asserted at byte 30 of a 100-byte frame → Gmii_tx_en=0 immediately; counters=0; after release a fresh 64-byte frame transmits correctly.
- Randomised traffic: mac_1g_tx upstream (frame lengths 60–1518, random valid gaps) with a scoreboard comparing GMII frames to expected frames → all match; Underrun_count=0 for frames fully buffered before start.
